l2_line_adapter: RTL and testbench

- Memory-side adapter for the L2 cache. It is the other end of the L2 line interface.
- The L2 issues whole-line reads and writes. The adapter turns each request into a fixed-length burst of narrow beats to main memory, and turns returning beats back into a full line.
- Sits between the L2 cache controller/datapath and the physical memory bus.
- One outstanding transaction at a time.

---
 rtl/l2_line_adapter.sv | 150 +++++++++++++++
 tb/tb_l2_line_adapter.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_line_adapter.sv
// L2 line adapter: turns whole-line L2 reads/writes into fixed-length beat bursts
// on the memory bus and reassembles returning beats into a full line.
module l2_line_adapter #(
  parameter int LINE_WIDTH  = 256,
  parameter int BURST_WIDTH = 64,
  parameter int ADDR_WIDTH  = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   line_read_i,
  input  logic                   line_write_i,
  input  logic [ADDR_WIDTH-1:0]  line_addr_i,
  input  logic [LINE_WIDTH-1:0]  line_data_i,
  output logic [LINE_WIDTH-1:0]  line_data_o,
  output logic                   line_resp_o,
  output logic                   mem_read_o,
  output logic                   mem_write_o,
  output logic [ADDR_WIDTH-1:0]  mem_addr_o,
  output logic [BURST_WIDTH-1:0] mem_data_o,
  input  logic [BURST_WIDTH-1:0] mem_data_i,
  input  logic                   mem_resp_i
);

  localparam int BEATS  = LINE_WIDTH / BURST_WIDTH;
  localparam int OFFSET = $clog2(LINE_WIDTH / 8);
  localparam int CW     = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_BURST = 2'd1,
    WR_BURST = 2'd2,
    DONE     = 2'd3
  } state_t;

  state_t                  state_r;
  state_t                  next_s;
  logic [CW-1:0]           beat_r;
  logic                    last_ack_s;
  logic                    mem_read_r;
  logic                    mem_write_r;
  logic                    line_resp_r;
  logic [ADDR_WIDTH-1:0]   mem_addr_r;
  logic [LINE_WIDTH-1:0]   line_data_r;
  logic [LINE_WIDTH-1:0]   wbuf_r;

  assign last_ack_s  = mem_resp_i && (beat_r == LAST_BEAT);

  assign line_data_o = line_data_r;
  assign line_resp_o = line_resp_r;
  assign mem_read_o  = mem_read_r;
  assign mem_write_o = mem_write_r;
  assign mem_addr_o  = mem_addr_r;
  // The write buffer shifts down one beat per ack, so its low slice is always the current beat.
  assign mem_data_o  = wbuf_r[BURST_WIDTH-1:0];

  // Next-state decode; read has priority over write when both are requested.
  always_comb begin
    next_s = state_r;
    case (state_r)
      IDLE: begin
        if (line_read_i) begin
          next_s = RD_BURST;
        end else if (line_write_i) begin
          next_s = WR_BURST;
        end else begin
          next_s = IDLE;
        end
      end
      RD_BURST, WR_BURST: begin
        if (last_ack_s) begin
          next_s = DONE;
        end else begin
          next_s = state_r;
        end
      end
      DONE:    next_s = IDLE;
      default: next_s = IDLE;
    endcase
  end

  // State register and registered handshake outputs, decoded from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      mem_read_r  <= 1'b0;
      mem_write_r <= 1'b0;
      line_resp_r <= 1'b0;
    end else begin
      state_r     <= next_s;
      mem_read_r  <= (next_s == RD_BURST);
      mem_write_r <= (next_s == WR_BURST);
      line_resp_r <= (next_s == DONE);
    end
  end

  // Beat counter: holds at the last beat after its ack, cleared only in DONE or reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_r <= '0;
    end else begin
      case (state_r)
        RD_BURST, WR_BURST: begin
          if (mem_resp_i && (beat_r != LAST_BEAT)) begin
            beat_r <= beat_r + CW'(1);
          end else begin
            beat_r <= beat_r;
          end
        end
        DONE:    beat_r <= '0;
        default: beat_r <= beat_r;
      endcase
    end
  end

  // Address latch and write buffer, loaded only when a request is accepted in IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_addr_r <= '0;
      wbuf_r     <= '0;
    end else if ((state_r == IDLE) && (line_read_i || line_write_i)) begin
      mem_addr_r <= {line_addr_i[ADDR_WIDTH-1:OFFSET], {OFFSET{1'b0}}};
      if (!line_read_i) begin
        wbuf_r <= line_data_i;
      end else begin
        wbuf_r <= wbuf_r;
      end
    end else if ((state_r == WR_BURST) && mem_resp_i) begin
      wbuf_r <= {{BURST_WIDTH{1'b0}}, wbuf_r[LINE_WIDTH-1:BURST_WIDTH]};
    end else begin
      wbuf_r <= wbuf_r;
    end
  end

  // Fill assembly: each accepted read beat lands in the slice selected by the beat counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      line_data_r <= '0;
    end else if ((state_r == RD_BURST) && mem_resp_i) begin
      for (int i = 0; i < BEATS; i++) begin
        if (beat_r == i[CW-1:0]) begin
          line_data_r[i*BURST_WIDTH +: BURST_WIDTH] <= mem_data_i;
        end
      end
    end else begin
      line_data_r <= line_data_r;
    end
  end

endmodule

// File: tb/tb_l2_line_adapter.sv
// Self-checking bench for l2_line_adapter: transaction-level reference model compared
// every cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_l2_line_adapter;

  localparam int LW = 256;
  localparam int BW = 64;
  localparam int AW = 32;
  localparam int NB = LW / BW;

  logic          clk = 1'b0;
  logic          rst;
  logic          line_read_i;
  logic          line_write_i;
  logic [AW-1:0] line_addr_i;
  logic [LW-1:0] line_data_i;
  logic [LW-1:0] line_data_o;
  logic          line_resp_o;
  logic          mem_read_o;
  logic          mem_write_o;
  logic [AW-1:0] mem_addr_o;
  logic [BW-1:0] mem_data_o;
  logic [BW-1:0] mem_data_i;
  logic          mem_resp_i;

  l2_line_adapter #(.LINE_WIDTH(LW), .BURST_WIDTH(BW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .line_read_i(line_read_i), .line_write_i(line_write_i),
    .line_addr_i(line_addr_i), .line_data_i(line_data_i),
    .line_data_o(line_data_o), .line_resp_o(line_resp_o),
    .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
    .mem_data_i(mem_data_i), .mem_resp_i(mem_resp_i)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n_rd_hi = 0;
  int n_wr_hi = 0;
  int n_resp  = 0;

  // Reference model: phase 0 idle, 1 reading, 2 writing, 3 complete.
  int            ph = 0;
  int            nb = 0;
  logic [BW-1:0] mline [NB];
  logic [BW-1:0] wrw   [NB];
  logic [AW-1:0] maddr = '0;

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [LW-1:0] r256();
    logic [LW-1:0] r;
    for (int i = 0; i < LW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic model_update();
    if (rst) begin
      ph = 0; nb = 0; maddr = '0;
      for (int i = 0; i < NB; i++) mline[i] = '0;
    end else begin
      case (ph)
        0: begin
          if (line_read_i) begin
            maddr = line_addr_i & ~32'h0000_001F; ph = 1; nb = 0;
          end else if (line_write_i) begin
            maddr = line_addr_i & ~32'h0000_001F; ph = 2; nb = 0;
            for (int i = 0; i < NB; i++) wrw[i] = line_data_i[i*BW +: BW];
          end
        end
        1: if (mem_resp_i) begin
          mline[nb] = mem_data_i; nb++;
          if (nb == NB) ph = 3;
        end
        2: if (mem_resp_i) begin
          nb++;
          if (nb == NB) ph = 3;
        end
        default: begin ph = 0; nb = 0; end
      endcase
    end
  endtask

  task automatic compare_all();
    chk("mem_read",  mem_read_o,  (ph == 1));
    chk("mem_write", mem_write_o, (ph == 2));
    chk("line_resp", line_resp_o, (ph == 3));
    chk("mem_addr",  mem_addr_o,  maddr);
    chk("line_data", line_data_o, {mline[3], mline[2], mline[1], mline[0]});
    if (ph == 2) chk("mem_data", mem_data_o, wrw[nb]);
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare_all();
    n_rd_hi += int'(mem_read_o);
    n_wr_hi += int'(mem_write_o);
    n_resp  += int'(line_resp_o);
  endtask

  task automatic run_to_resp(input int bound, input bit stall);
    bit got = 1'b0;
    for (int c = 0; c < bound && !got; c++) begin
      mem_resp_i = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      mem_data_i = {$urandom, $urandom};
      step();
      line_addr_i = $urandom;
      line_data_i = r256();
      if (line_resp_o) got = 1'b1;
    end
    chk("resp_timeout", got, 1'b1);
    line_read_i = 1'b0; line_write_i = 1'b0; mem_resp_i = 1'b0;
  endtask

  task automatic read_known(input logic [AW-1:0] a, input logic [BW-1:0] base);
    line_read_i = 1'b1; line_addr_i = a; mem_resp_i = 1'b0;
    step();
    for (int b = 0; b < NB; b++) begin
      mem_resp_i = 1'b1; mem_data_i = base + 64'(b);
      step();
    end
    chk("rk_resp", line_resp_o, 1'b1);
    chk("rk_line", line_data_o, {base + 64'd3, base + 64'd2, base + 64'd1, base});
    line_read_i = 1'b0; mem_resp_i = 1'b0;
    step();
  endtask

  initial begin
    logic [BW-1:0] d [NB];
    logic [BW-1:0] expseq [7];
    logic          pat [7];
    rst = 1'b1; line_read_i = 1'b0; line_write_i = 1'b0; line_addr_i = '0;
    line_data_i = '0; mem_data_i = '0; mem_resp_i = 1'b0;
    for (int i = 0; i < NB; i++) begin mline[i] = '0; wrw[i] = '0; end
    repeat (3) step();
    chk("rst_read", mem_read_o, 1'b0);
    chk("rst_write", mem_write_o, 1'b0);
    chk("rst_resp", line_resp_o, 1'b0);
    chk("rst_addr", mem_addr_o, 32'h0);
    chk("rst_mdata", mem_data_o, 64'h0);
    chk("rst_line", line_data_o, 256'h0);
    rst = 1'b0;
    step();

    // Read without stalls.
    n_rd_hi = 0; n_resp = 0;
    line_read_i = 1'b1; line_addr_i = 32'h0000_1234;
    step();
    chk("t1_addr", mem_addr_o, 32'h0000_1220);
    for (int b = 0; b < NB; b++) begin
      mem_resp_i = 1'b1; mem_data_i = 64'h1111_1111_1111_1111 * 64'(b + 1);
      step();
      if (b < NB - 1) chk("t1_early_resp", line_resp_o, 1'b0);
    end
    chk("t1_resp", line_resp_o, 1'b1);
    chk("t1_line", line_data_o, {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                 64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});
    line_read_i = 1'b0; mem_resp_i = 1'b0;
    step(); step();
    chk("t1_rd_cycles", n_rd_hi, 4);
    chk("t1_resp_pulses", n_resp, 1);

    // Write with stalls.
    for (int i = 0; i < NB; i++) d[i] = 64'hD00D_0000_0000_0000 + 64'(i);
    expseq = '{d[0], d[1], d[1], d[1], d[2], d[3], d[3]};
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    n_resp = 0;
    line_write_i = 1'b1; line_addr_i = 32'hABCD_EF7F; line_data_i = {d[3], d[2], d[1], d[0]};
    step();
    chk("t2_addr", mem_addr_o, 32'hABCD_EF60);
    line_data_i = r256();
    for (int j = 0; j < 7; j++) begin
      chk("t2_mdata", mem_data_o, expseq[j]);
      chk("t2_write_hi", mem_write_o, 1'b1);
      mem_resp_i = pat[j];
      step();
    end
    chk("t2_write_drop", mem_write_o, 1'b0);
    chk("t2_resp", line_resp_o, 1'b1);
    line_write_i = 1'b0; mem_resp_i = 1'b0;
    step();
    chk("t2_resp_pulses", n_resp, 1);

    // Simultaneous read and write: read wins, write later on its own.
    line_read_i = 1'b1; line_write_i = 1'b1; line_addr_i = 32'h0000_4000;
    step();
    chk("t3_read", mem_read_o, 1'b1);
    chk("t3_nowrite", mem_write_o, 1'b0);
    line_write_i = 1'b0;
    run_to_resp(200, 1'b1);
    step();
    n_wr_hi = 0;
    line_write_i = 1'b1; line_data_i = r256();
    run_to_resp(200, 1'b1);
    chk("t3_write_ran", (n_wr_hi >= NB), 1'b1);
    step();

    // Reset mid-read after two beats.
    line_read_i = 1'b1; line_addr_i = 32'h0000_8040;
    step();
    for (int b = 0; b < 2; b++) begin
      mem_resp_i = 1'b1; mem_data_i = {$urandom, $urandom};
      step();
    end
    n_resp = 0;
    rst = 1'b1; line_read_i = 1'b0; mem_resp_i = 1'b0;
    step();
    chk("t4_read", mem_read_o, 1'b0);
    chk("t4_resp", line_resp_o, 1'b0);
    chk("t4_addr", mem_addr_o, 32'h0);
    chk("t4_line", line_data_o, 256'h0);
    rst = 1'b0;
    step();
    chk("t4_no_resp", n_resp, 0);
    read_known(32'h0000_9000, 64'hFEED_0000_0000_0010);

    // Spurious memory acks while idle.
    for (int i = 0; i < 3; i++) begin
      mem_resp_i = 1'b1; mem_data_i = {$urandom, $urandom};
      step();
      chk("t6_line", line_data_o, {64'hFEED_0000_0000_0013, 64'hFEED_0000_0000_0012,
                                   64'hFEED_0000_0000_0011, 64'hFEED_0000_0000_0010});
      chk("t6_read", mem_read_o, 1'b0);
    end
    mem_resp_i = 1'b0;
    read_known(32'h0000_A020, 64'hC0DE_0000_0000_0100);

    // Back-to-back: read held one cycle past the response.
    line_read_i = 1'b1; line_addr_i = 32'h0000_B000;
    step();
    for (int b = 0; b < NB; b++) begin
      mem_resp_i = 1'b1; mem_data_i = {$urandom, $urandom};
      step();
    end
    chk("t5_resp", line_resp_o, 1'b1);
    mem_resp_i = 1'b0;
    step();
    chk("t5_gap", mem_read_o, 1'b0);
    step();
    chk("t5_reassert", mem_read_o, 1'b1);
    run_to_resp(200, 1'b1);
    step();

    // Randomized traffic with occasional resets and idle spurious acks.
    for (int t = 0; t < 150; t++) begin
      case ($urandom_range(0, 2))
        0:       begin line_read_i = 1'b1; line_write_i = 1'b0; end
        1:       begin line_read_i = 1'b0; line_write_i = 1'b1; end
        default: begin line_read_i = 1'b1; line_write_i = 1'b1; end
      endcase
      line_addr_i = $urandom; line_data_i = r256();
      if ($urandom_range(0, 9) == 0) begin
        repeat ($urandom_range(1, 6)) begin
          mem_resp_i = 1'($urandom_range(0, 1)); mem_data_i = {$urandom, $urandom};
          step();
          if (line_resp_o) begin line_read_i = 1'b0; line_write_i = 1'b0; end
        end
        rst = 1'b1; line_read_i = 1'b0; line_write_i = 1'b0;
        step();
        rst = 1'b0;
      end else begin
        run_to_resp(200, 1'b1);
      end
      repeat ($urandom_range(0, 3)) begin
        mem_resp_i = 1'($urandom_range(0, 1)); mem_data_i = {$urandom, $urandom};
        step();
      end
      mem_resp_i = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
